// File: rtl/image_frame_loader_pkg.sv
// Shared widths, state encoding and address constants for the frame loader
// and its pixel register file.
package image_frame_loader_pkg;

  localparam int PIX_W  = 4;
  localparam int N_PIX  = 16;
  localparam int ADDR_W = 4;

  localparam logic [ADDR_W-1:0] FRAME_LAST_ADDR = 4'd15;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_LOAD = 2'b01,
    ST_FULL = 2'b10
  } state_e;

  function automatic logic is_last_addr(input logic [ADDR_W-1:0] addr);
    return addr == FRAME_LAST_ADDR;
  endfunction

endpackage

// File: rtl/image_frame_loader_pixel_regfile.sv
// 16-entry pixel store: one synchronous write port, one combinational read
// port, all entries cleared by the asynchronous reset.
module image_frame_loader_pixel_regfile
  import image_frame_loader_pkg::*;
(
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] waddr_i,
  input  logic [PIX_W-1:0]  wdata_i,
  input  logic [ADDR_W-1:0] raddr_i,
  output logic [PIX_W-1:0]  rdata_o
);

  logic [PIX_W-1:0] mem_q [N_PIX];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < N_PIX; i++) mem_q[i] <= '0;
    end else if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  // Read-before-write: a same-cycle write only becomes visible after the edge.
  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/image_frame_loader.sv
// Writer side of the convolution pixel store: fills a 4x4 frame from a
// valid/ready stream and holds it until the consumer releases it.
//   state | meaning
//   IDLE  | just out of reset, not yet accepting
//   LOAD  | accepting pixels in raster order
//   FULL  | frame complete and stable, waiting for release
module image_frame_loader
  import image_frame_loader_pkg::*;
(
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              in_valid_i,
  input  logic [PIX_W-1:0]  in_pix_i,
  input  logic              in_last_i,
  output logic              in_ready_o,
  output logic              frame_ready_o,
  input  logic              release_i,
  input  logic [ADDR_W-1:0] rd_addr_i,
  output logic [PIX_W-1:0]  rd_pix_o,
  output logic [ADDR_W-1:0] wr_ptr_o,
  output logic [3:0]        frame_cnt_o,
  output logic              err_o,
  input  logic              err_clr_i
);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [3:0]        frame_cnt_q, frame_cnt_d;
  logic              err_q, err_d;
  logic              err_set;
  logic              we;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= ST_IDLE;
      wr_ptr_q    <= '0;
      frame_cnt_q <= '0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      wr_ptr_q    <= wr_ptr_d;
      frame_cnt_q <= frame_cnt_d;
      err_q       <= err_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    wr_ptr_d    = wr_ptr_q;
    frame_cnt_d = frame_cnt_q;
    err_set     = 1'b0;
    we          = 1'b0;
    case (state_q)
      ST_IDLE: state_d = ST_LOAD;
      ST_LOAD: begin
        if (in_valid_i) begin
          we = 1'b1;
          if (is_last_addr(wr_ptr_q)) begin
            // A missing IN_LAST still completes the frame, but is flagged.
            wr_ptr_d    = '0;
            frame_cnt_d = frame_cnt_q + 4'd1;
            state_d     = ST_FULL;
            err_set     = ~in_last_i;
          end else if (in_last_i) begin
            // Early last: the partial frame is abandoned, stale pixels stay.
            wr_ptr_d = '0;
            err_set  = 1'b1;
          end else begin
            wr_ptr_d = wr_ptr_q + ADDR_W'(1);
          end
        end
      end
      ST_FULL: if (release_i) state_d = ST_LOAD;
      default: state_d = ST_IDLE;
    endcase
    err_d = err_set | (err_q & ~err_clr_i);
  end

  image_frame_loader_pixel_regfile u_regfile (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .we_i    (we),
    .waddr_i (wr_ptr_q),
    .wdata_i (in_pix_i),
    .raddr_i (rd_addr_i),
    .rdata_o (rd_pix_o)
  );

  assign in_ready_o    = (state_q == ST_LOAD);
  assign frame_ready_o = (state_q == ST_FULL);
  assign wr_ptr_o      = wr_ptr_q;
  assign frame_cnt_o   = frame_cnt_q;
  assign err_o         = err_q;

endmodule

// File: doc/image_frame_loader.md
Name: image_frame_loader

Overview:
- Writer side of the convolution pixel store.
- Accepts a 4x4 frame of 4-bit pixels as a serial valid/ready stream in raster order (address 0..15) and fills a 16-entry register file.
- Presents the frame to the convolution datapath through an asynchronous read port. The 4-bit window address generator drives that port with the repeating sequence 10,11,13,14,15,5,6,7,9.
- Handshakes frame-full/release with the convolution controller so a frame is never overwritten mid-use.

Parameters:
- PIX_W, 4, pixel width in bits.
- N_PIX, 16, pixels per frame (4x4).
- ADDR_W, 4, register-file address width.

Ports:
- CLK  in  1  system clock, rising edge.
- RESET  in  1  asynchronous, active-low reset.
- IN_VALID  in  1  producer has a pixel on IN_PIX.
- IN_PIX  in  PIX_W  pixel value.
- IN_LAST  in  1  marks the final pixel of a frame.
- IN_READY  out  1  loader accepts a pixel this cycle.
- FRAME_READY  out  1  complete frame held; contents stable.
- RELEASE  in  1  consumer is done with the frame (single-cycle pulse).
- RD_ADDR  in  ADDR_W  read address from the window address generator.
- RD_PIX  out  PIX_W  mem[RD_ADDR], combinational.
- WR_PTR  out  ADDR_W  next raster write address.
- FRAME_CNT  out  4  completed-frame count, wraps 15->0.
- ERR  out  1  sticky IN_LAST/length mismatch.
- ERR_CLR  in  1  clears ERR.

Behaviour:
- Reset (RESET=0, asynchronous):
  - state=IDLE, WR_PTR=0, FRAME_CNT=0, ERR=0.
  - IN_READY=0, FRAME_READY=0.
  - All 16 entries=0, so RD_PIX=0.
- States:
  - IDLE -> LOAD on the first CLK edge after RESET deasserts.
  - LOAD: IN_READY=1, FRAME_READY=0.
  - FULL: IN_READY=0, FRAME_READY=1.
- IN_READY and FRAME_READY are registered state decodes; neither depends combinationally on inputs.
- Handshake: a beat transfers on a CLK edge with IN_VALID=1 and IN_READY=1.
  - Producer holds IN_PIX/IN_LAST stable while IN_VALID=1 and IN_READY=0.
  - IN_VALID may drop between beats; no beat is lost or duplicated.
- LOAD, accepted beat with WR_PTR<15:
  - mem[WR_PTR]<=IN_PIX; WR_PTR<=WR_PTR+1.
  - If IN_LAST=1 (early last): the pixel is still written, then ERR<=1, WR_PTR<=0, stay LOAD. The partial frame is discarded logically; stale contents remain.
- LOAD, accepted beat with WR_PTR=15:
  - mem[15]<=IN_PIX; WR_PTR<=0; FRAME_CNT<=FRAME_CNT+1 (mod 16); state<=FULL.
  - If IN_LAST=0 (missing last): the frame still completes and ERR<=1.
- Latency: FRAME_READY=1 and IN_READY=0 in the cycle after the 16th handshake.
- FULL:
  - No writes.
  - RELEASE=1 -> LOAD next edge (IN_READY=1, FRAME_READY=0). Contents are retained until overwritten.
  - RELEASE in LOAD or IDLE is ignored.
- Read port:
  - RD_PIX=mem[RD_ADDR], zero-cycle combinational, legal in every state.
  - Same-cycle write to RD_ADDR: RD_PIX shows the old value until the edge, the new value after it.
- ERR:
  - Set has priority over ERR_CLR in the same cycle.
  - Otherwise ERR_CLR=1 clears ERR on the edge.
- Reset mid-load or mid-FULL aborts immediately to the reset values; no partial frame survives.
- Widths: WR_PTR and FRAME_CNT use natural 4-bit wrap; no saturation.

Decomposition:
- Shared package holds:
  - PIX_W, N_PIX, ADDR_W.
  - State encoding: IDLE=2'b00, LOAD=2'b01, FULL=2'b10.
  - FRAME_LAST_ADDR=4'd15.
- Sub-module pixel_regfile: 16 x PIX_W storage with async clear, one write port (we, waddr, wdata) and one asynchronous read port.
- image_frame_loader holds the FSM, pointer, counters and ERR.

Test Plan:
- Reset, then release: IN_READY=0 and RD_PIX=0 for all 16 addresses during reset; IN_READY=1 one edge after release; WR_PTR=0, FRAME_CNT=0.
- Stream pixel value=address 0..15, IN_LAST on beat 16: FRAME_READY=1 and IN_READY=0 one cycle later; FRAME_CNT=1; RD_ADDR 10,11,13,14,15,5,6,7,9 returns 0xA,0xB,0xD,0xE,0xF,0x5,0x6,0x7,0x9.
- Backpressure: in FULL, hold IN_VALID=1 with IN_PIX=0xF for 5 cycles -> memory unchanged, IN_READY stays 0; RELEASE pulse -> IN_READY=1, FRAME_READY=0 next cycle, then 0xF is accepted at address 0.
- Early IN_LAST on beat 8 -> ERR=1, WR_PTR=0, FRAME_READY stays 0; 16 clean beats then fill a frame normally; ERR_CLR -> ERR=0.
- Random IN_VALID gaps (~50% duty) over 3 frames with RELEASE between frames -> exactly 16 writes per frame, FRAME_CNT=3, no lost or duplicated beats.
- Assert RESET asynchronously (off clock edge) after beat 7 -> IN_READY, FRAME_READY, WR_PTR and RD_PIX go to 0 immediately, without waiting for CLK; next frame loads from address 0.
